// File: rtl/mips_pkg.sv
// Opcode/funct constants and write-data select encoding shared by the W stage.
// Build option: WB_RETIRE_CNT_EN (consumed by wb_stage_pipe).
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_ADDEI   = 6'b110011;

    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_JR      = 6'b001000;

    // Link register written by jal.
    localparam logic [4:0] REG_RA     = 5'd31;

    typedef enum logic [1:0] {
        WD_SEL_ALU = 2'd0,
        WD_SEL_DM  = 2'd1,
        WD_SEL_PC8 = 2'd2
    } wd_sel_e;

    function automatic logic is_rtype(input logic [5:0] op);
        return op == OP_SPECIAL;
    endfunction

endpackage

// File: rtl/w_instr_dec.sv
// W-stage instruction decoder: instruction word -> GRF write intent, address, data source.
// Purely combinational; $0 suppression and valid gating live in the top level.
module w_instr_dec
    import mips_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [31:0]     instr,
    output logic            wr,
    output logic [RA_W-1:0] a3,
    output logic [1:0]      wd_sel
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       is_add, is_sub, is_ori, is_lw, is_lui, is_jal, is_addei;
    logic       unused_bits;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // rs and shamt never influence the write side of the pipeline.
    assign unused_bits = ^{instr[25:21], instr[10:6]};

    assign is_add   = is_rtype(op) && (funct == FN_ADD);
    assign is_sub   = is_rtype(op) && (funct == FN_SUB);
    assign is_ori   = (op == OP_ORI);
    assign is_lw    = (op == OP_LW);
    assign is_lui   = (op == OP_LUI);
    assign is_jal   = (op == OP_JAL);
    assign is_addei = (op == OP_ADDEI);

    always_comb begin
        wr     = 1'b0;
        a3     = '0;
        wd_sel = WD_SEL_ALU;

        wr = is_add | is_sub | is_ori | is_lw | is_lui | is_jal | is_addei;

        if (is_add || is_sub) begin
            a3 = RA_W'(instr[15:11]);
        end else if (is_ori || is_lw || is_lui || is_addei) begin
            a3 = RA_W'(instr[20:16]);
        end else if (is_jal) begin
            a3 = RA_W'(REG_RA);
        end

        if (is_lw) begin
            wd_sel = WD_SEL_DM;
        end else if (is_jal) begin
            wd_sel = WD_SEL_PC8;
        end
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback stage: M/W pipeline register, W decode, GRF write port and W-level forwarding source.
// Build option: WB_RETIRE_CNT_EN adds the W_retire_cnt port and retired-instruction counter.
module wb_stage_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              W_en,
    input  logic              W_flush,
    input  logic              M_valid,
    input  logic [31:0]       M_instr,
    input  logic [PC_W-1:0]   M_pc,
    input  logic [DATA_W-1:0] M_alu_res,
    input  logic [DATA_W-1:0] M_dm_rdata,
    output logic              W_valid,
    output logic [PC_W-1:0]   W_pc,
    output logic              W_grf_we,
    output logic [RA_W-1:0]   W_grf_a3,
    output logic [DATA_W-1:0] W_grf_wd,
    output logic [1:0]        W_Tnew
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]  W_retire_cnt
`endif
);

    // Advance protocol: the hazard unit drives W_en=1 when the M slot may move into W
    // and W_flush=1 to load a bubble; flush dominates, and with both low W holds.
    logic [31:0]       instr_q, instr_d;
    logic [PC_W-1:0]   pc_q,    pc_d;
    logic [DATA_W-1:0] alu_q,   alu_d;
    logic [DATA_W-1:0] dm_q,    dm_d;
    logic              valid_q, valid_d;
    logic              w_update;

    assign w_update = W_en | W_flush;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        alu_d   = alu_q;
        dm_d    = dm_q;
        valid_d = valid_q;
        if (W_flush) begin
            instr_d = '0;
            pc_d    = '0;
            alu_d   = '0;
            dm_d    = '0;
            valid_d = 1'b0;
        end else if (W_en) begin
            instr_d = M_instr;
            pc_d    = M_pc;
            alu_d   = M_alu_res;
            dm_d    = M_dm_rdata;
            valid_d = M_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            dm_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            alu_q   <= alu_d;
            dm_q    <= dm_d;
            valid_q <= valid_d;
        end
    end

    logic            dec_wr;
    logic [RA_W-1:0] dec_a3;
    logic [1:0]      dec_wd_sel;

    w_instr_dec #(
        .RA_W   (RA_W)
    ) u_dec (
        .instr  (instr_q),
        .wr     (dec_wr),
        .a3     (dec_a3),
        .wd_sel (dec_wd_sel)
    );

    // Link value is computed in PC width, then resized to the data width.
    logic [PC_W-1:0] pc_plus8;
    assign pc_plus8 = pc_q + PC_W'(8);

    always_comb begin
        W_grf_wd = alu_q;
        case (dec_wd_sel)
            WD_SEL_DM:  W_grf_wd = dm_q;
            WD_SEL_PC8: W_grf_wd = DATA_W'(pc_plus8);
            default:    W_grf_wd = alu_q;
        endcase
    end

    // Writes to $0 are dropped here so the hazard unit never forwards from $0.
    assign W_valid  = valid_q;
    assign W_pc     = pc_q;
    assign W_grf_a3 = dec_a3;
    assign W_grf_we = valid_q & dec_wr & (dec_a3 != '0);
    assign W_Tnew   = 2'b00;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (valid_q && w_update) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign W_retire_cnt = retire_cnt_q;
`else
    logic unused_update;
    assign unused_update = w_update;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: decode vector table, reset/stall/flush sequences and,
// when WB_RETIRE_CNT_EN is defined, the retire counter with CNT_W=4.
module tb_wb_stage_pipe;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int RA_W   = 5;
`ifdef WB_RETIRE_CNT_EN
    localparam int CNT_W  = 4;
`else
    localparam int CNT_W  = 32;
`endif
    localparam int EXP_W  = 2 + 1 + 1 + RA_W + DATA_W + PC_W;

    localparam logic [31:0] I_ADD3   = 32'h0022_1820;
    localparam logic [31:0] I_SUB7   = 32'h0022_3822;
    localparam logic [31:0] I_ADD0   = 32'h0022_0020;
    localparam logic [31:0] I_ADDU   = 32'h0022_1821;
    localparam logic [31:0] I_LW8    = 32'h8C08_0000;
    localparam logic [31:0] I_SW     = 32'hAC08_0004;
    localparam logic [31:0] I_BEQ    = 32'h1022_0003;
    localparam logic [31:0] I_JR     = 32'h03E0_0008;
    localparam logic [31:0] I_JAL    = 32'h0C00_0C02;
    localparam logic [31:0] I_BADOP  = 32'hFC00_0000;
    localparam logic [31:0] I_ORI0   = 32'h3420_0005;
    localparam logic [31:0] I_ORI5   = 32'h3425_0005;
    localparam logic [31:0] I_LUI9   = 32'h3C09_0012;
    localparam logic [31:0] I_ADDEI4 = 32'hCC24_0001;

    logic              clk;
    logic              reset;
    logic              W_en;
    logic              W_flush;
    logic              M_valid;
    logic [31:0]       M_instr;
    logic [PC_W-1:0]   M_pc;
    logic [DATA_W-1:0] M_alu_res;
    logic [DATA_W-1:0] M_dm_rdata;
    logic              W_valid;
    logic [PC_W-1:0]   W_pc;
    logic              W_grf_we;
    logic [RA_W-1:0]   W_grf_a3;
    logic [DATA_W-1:0] W_grf_wd;
    logic [1:0]        W_Tnew;
`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0]  W_retire_cnt;
`endif

    wb_stage_pipe #(
        .DATA_W       (DATA_W),
        .PC_W         (PC_W),
        .RA_W         (RA_W),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .W_en         (W_en),
        .W_flush      (W_flush),
        .M_valid      (M_valid),
        .M_instr      (M_instr),
        .M_pc         (M_pc),
        .M_alu_res    (M_alu_res),
        .M_dm_rdata   (M_dm_rdata),
        .W_valid      (W_valid),
        .W_pc         (W_pc),
        .W_grf_we     (W_grf_we),
        .W_grf_a3     (W_grf_a3),
        .W_grf_wd     (W_grf_wd),
        .W_Tnew       (W_Tnew)
`ifdef WB_RETIRE_CNT_EN
        ,
        .W_retire_cnt (W_retire_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_vec;
    int n_err;

    function automatic logic [EXP_W-1:0] pack_exp(input logic v, input logic we,
                                                   input logic [RA_W-1:0] a3,
                                                   input logic [DATA_W-1:0] wd,
                                                   input logic [PC_W-1:0] pc);
        return {2'b00, v, we, a3, wd, pc};
    endfunction

    task automatic check_out(input string name);
        logic [EXP_W-1:0] exp_v;
        logic [EXP_W-1:0] act_v;
        n_vec++;
        act_v = {W_Tnew, W_valid, W_grf_we, W_grf_a3, W_grf_wd, W_pc};
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h", name, act_v);
        end else begin
            exp_v = exp_q.pop_front();
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL %s: got tnew=%0d valid=%0d we=%0d a3=%0d wd=%h pc=%h, want tnew=%0d valid=%0d we=%0d a3=%0d wd=%h pc=%h",
                         name, W_Tnew, W_valid, W_grf_we, W_grf_a3, W_grf_wd, W_pc,
                         exp_v[EXP_W-1 -: 2], exp_v[EXP_W-3], exp_v[EXP_W-4],
                         exp_v[DATA_W+PC_W +: RA_W], exp_v[PC_W +: DATA_W], exp_v[PC_W-1:0]);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic en, input logic fl, input logic v,
                         input logic [31:0] ins, input logic [PC_W-1:0] pc,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] dm);
        @(negedge clk);
        reset      = rst;
        W_en       = en;
        W_flush    = fl;
        M_valid    = v;
        M_instr    = ins;
        M_pc       = pc;
        M_alu_res  = alu;
        M_dm_rdata = dm;
    endtask

    task automatic tick_check(input string name);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              v;
        logic [31:0]       instr;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] dm;
        logic              e_we;
        logic [RA_W-1:0]   e_a3;
        logic [DATA_W-1:0] e_wd;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] exp_cnt;
    logic             model_valid;

    task automatic cnt_step(input logic en, input logic fl, input logic v, input string name);
        drive(1'b0, en, fl, v, I_ADD3, 32'h400, 32'h1, 32'h0);
        if (en || fl) begin
            if (model_valid) exp_cnt = exp_cnt + 1'b1;
            model_valid = fl ? 1'b0 : v;
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (W_retire_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL %s: retire_cnt got %0d want %0d", name, W_retire_cnt, exp_cnt);
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; W_en = 1'b0; W_flush = 1'b0; M_valid = 1'b0;
        M_instr = '0; M_pc = '0; M_alu_res = '0; M_dm_rdata = '0;

        vecs[0]  = '{1'b1, I_ADD3,   32'h0000_1000, 32'h0000_0005, 32'h0,         1'b1, 5'd3,  32'h0000_0005};
        vecs[1]  = '{1'b1, I_LW8,    32'h0000_1004, 32'h0000_0010, 32'hDEADBEEF, 1'b1, 5'd8,  32'hDEADBEEF};
        vecs[2]  = '{1'b1, I_JAL,    32'h0000_3000, 32'h0000_0077, 32'h1,         1'b1, 5'd31, 32'h0000_3008};
        vecs[3]  = '{1'b1, I_SW,     32'h0000_3008, 32'h0000_0020, 32'h2,         1'b0, 5'd0,  32'h0000_0020};
        vecs[4]  = '{1'b1, I_BEQ,    32'h0000_300C, 32'h0000_0001, 32'h3,         1'b0, 5'd0,  32'h0000_0001};
        vecs[5]  = '{1'b1, I_JR,     32'h0000_3010, 32'h0000_0042, 32'h4,         1'b0, 5'd0,  32'h0000_0042};
        vecs[6]  = '{1'b1, I_BADOP,  32'h0000_3014, 32'h0000_0099, 32'h5,         1'b0, 5'd0,  32'h0000_0099};
        vecs[7]  = '{1'b1, I_ORI0,   32'h0000_3018, 32'h0000_0005, 32'h6,         1'b0, 5'd0,  32'h0000_0005};
        vecs[8]  = '{1'b1, I_ORI5,   32'h0000_301C, 32'h0000_1234, 32'h7,         1'b1, 5'd5,  32'h0000_1234};
        vecs[9]  = '{1'b1, I_LUI9,   32'h0000_3020, 32'h0012_0000, 32'h8,         1'b1, 5'd9,  32'h0012_0000};
        vecs[10] = '{1'b1, I_ADDEI4, 32'h0000_3024, 32'hFFFF_FFFF, 32'h9,         1'b1, 5'd4,  32'hFFFF_FFFF};
        vecs[11] = '{1'b1, I_SUB7,   32'h0000_3028, 32'h0000_000A, 32'hA,         1'b1, 5'd7,  32'h0000_000A};
        vecs[12] = '{1'b1, 32'h0,    32'h0000_302C, 32'h0000_0055, 32'hB,         1'b0, 5'd0,  32'h0000_0055};
        vecs[13] = '{1'b1, I_ADD0,   32'h0000_3030, 32'h0000_0066, 32'hC,         1'b0, 5'd0,  32'h0000_0066};
        vecs[14] = '{1'b0, I_ADD3,   32'h0000_3034, 32'h0000_0077, 32'hD,         1'b0, 5'd3,  32'h0000_0077};
        vecs[15] = '{1'b1, I_ADDU,   32'h0000_3038, 32'h0000_0088, 32'hE,         1'b0, 5'd0,  32'h0000_0088};
        vecs[16] = '{1'b1, I_JAL,    32'hFFFF_FFF8, 32'h0000_0011, 32'hF,         1'b1, 5'd31, 32'h0000_0000};

        // Reset held while the M stage offers a valid add: W must stay empty.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, I_ADD3, 32'h100, 32'h5, 32'h0);
            exp_q.push_back(pack_exp(1'b0, 1'b0, '0, '0, '0));
            tick_check($sformatf("reset_hold%0d", i));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, I_ADD3, 32'h104, 32'h5, 32'h0);
        exp_q.push_back(pack_exp(1'b1, 1'b1, 5'd3, 32'h5, 32'h104));
        tick_check("post_reset_add");

        for (int i = 0; i < NV; i++) begin
            drive(1'b0, 1'b1, 1'b0, vecs[i].v, vecs[i].instr, vecs[i].pc, vecs[i].alu, vecs[i].dm);
            exp_q.push_back(pack_exp(vecs[i].v, vecs[i].e_we, vecs[i].e_a3, vecs[i].e_wd, vecs[i].pc));
            tick_check($sformatf("vec%0d", i));
        end

        // Stall: held ori keeps writing; M inputs change underneath.
        drive(1'b0, 1'b1, 1'b0, 1'b1, I_ORI5, 32'h200, 32'hABCD, 32'h0);
        exp_q.push_back(pack_exp(1'b1, 1'b1, 5'd5, 32'hABCD, 32'h200));
        tick_check("stall_load");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, I_LW8, 32'h999 + i, 32'h0, 32'h1111);
            exp_q.push_back(pack_exp(1'b1, 1'b1, 5'd5, 32'hABCD, 32'h200));
            tick_check($sformatf("stall%0d", i));
        end

        // Flush beats enable.
        drive(1'b0, 1'b1, 1'b1, 1'b1, I_ADD3, 32'h300, 32'h7, 32'h0);
        exp_q.push_back(pack_exp(1'b0, 1'b0, '0, '0, '0));
        tick_check("flush_over_en");

        // Flush with enable low still clears.
        drive(1'b0, 1'b1, 1'b0, 1'b1, I_LW8, 32'h304, 32'h0, 32'h5A5A5A5A);
        exp_q.push_back(pack_exp(1'b1, 1'b1, 5'd8, 32'h5A5A5A5A, 32'h304));
        tick_check("lw_before_flush");
        drive(1'b0, 1'b0, 1'b1, 1'b1, I_LW8, 32'h308, 32'h0, 32'h1);
        exp_q.push_back(pack_exp(1'b0, 1'b0, '0, '0, '0));
        tick_check("flush_no_en");

        // Reset mid-stream wipes a loaded writer.
        drive(1'b0, 1'b1, 1'b0, 1'b1, I_JAL, 32'h400, 32'h0, 32'h0);
        exp_q.push_back(pack_exp(1'b1, 1'b1, 5'd31, 32'h408, 32'h400));
        tick_check("jal_before_reset");
        drive(1'b1, 1'b1, 1'b0, 1'b1, I_LW8, 32'h404, 32'h0, 32'h2222);
        exp_q.push_back(pack_exp(1'b0, 1'b0, '0, '0, '0));
        tick_check("midstream_reset");

`ifdef WB_RETIRE_CNT_EN
        exp_cnt = '0;
        model_valid = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        n_vec++;
        if (W_retire_cnt !== '0) begin
            n_err++;
            $display("FAIL cnt_reset: retire_cnt got %0d want 0", W_retire_cnt);
        end
        for (int i = 0; i < 17; i++) begin
            cnt_step(1'b1, 1'b0, 1'b1, $sformatf("cnt_adv%0d", i));
            if (i % 5 == 2) cnt_step(1'b0, 1'b0, 1'b1, $sformatf("cnt_stall%0d", i));
        end
        cnt_step(1'b1, 1'b0, 1'b0, "cnt_bubble_in");
        cnt_step(1'b1, 1'b0, 1'b0, "cnt_bubble_out");
        cnt_step(1'b0, 1'b1, 1'b1, "cnt_flush_bubble");
        n_vec++;
        if (W_retire_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL cnt_wrap: retire_cnt got %0d want 1", W_retire_cnt);
        end
`endif

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
